// File: rtl/lfsr_pad_encrypt.sv
// Pad-and-whiten encryptor: reads plaintext plus three config bytes, left-pads with spaces,
// XORs each byte with a 7-bit LFSR keystream, adds even parity and writes 64 ciphertext bytes.
module lfsr_pad_encrypt #(
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned CFG_BASE = 61,
  parameter int unsigned OUT_BASE = 64,
  parameter int unsigned OUT_LEN  = 64,
  parameter int unsigned MSG_SPAN = 61
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData
);

  localparam int unsigned AW = 8;
  localparam int unsigned LW = 7;
  localparam logic [AW-1:0] LAST_IDX = AW'(OUT_LEN - 1);

  typedef enum logic [2:0] {IDLE, C0, C1, C2, C3, RD, WR, DONE} state_t;

  state_t        state;
  logic          start_q;
  logic [3:0]    pre;
  logic [LW-1:0] taps;
  logic [LW-1:0] lfsr;
  logic [AW-1:0] idx;

  logic [AW-1:0] j_c;
  logic [LW-1:0] diff_c;
  logic [LW-1:0] ct_c;
  logic          is_pad_c;
  logic          unused_c;

  // Plaintext address for output index i; pad indices produce a harmless don't-care address.
  function automatic logic [AW-1:0] msg_addr(input logic [AW-1:0] i, input logic [3:0] p);
    logic [AW-1:0] j;
    j = i - AW'(p);
    return AW'(MSG_BASE) + AW'(j[5:0]);
  endfunction

  // Read data arrives during WR, so the ciphertext byte is formed combinationally there.
  always_comb begin
    j_c       = idx - AW'(pre);
    diff_c    = MemRdData[LW-1:0] - LW'(8'h20);
    is_pad_c  = (idx < AW'(pre)) || (32'(j_c) >= MSG_SPAN);
    ct_c      = (is_pad_c ? '0 : diff_c) ^ lfsr;
    MemWrData = (state == WR) ? {^ct_c, ct_c} : '0;
    unused_c  = MemRdData[7];
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      Ack     <= 1'b0;
      MemWrEn <= 1'b0;
      MemAddr <= '0;
      pre     <= '0;
      taps    <= '0;
      lfsr    <= '0;
      idx     <= '0;
    end else begin
      start_q <= Start;
      case (state)
        IDLE: begin
          if (!Start && start_q) begin
            state   <= C0;
            MemAddr <= AW'(CFG_BASE);
          end
        end
        C0: begin
          state   <= C1;
          MemAddr <= AW'(CFG_BASE + 1);
        end
        C1: begin
          state   <= C2;
          MemAddr <= AW'(CFG_BASE + 2);
          pre     <= MemRdData[3:0];
        end
        C2: begin
          state <= C3;
          taps  <= MemRdData[LW-1:0];
        end
        C3: begin
          state   <= RD;
          lfsr    <= MemRdData[LW-1:0];
          idx     <= '0;
          MemAddr <= msg_addr('0, pre);
        end
        RD: begin
          state   <= WR;
          MemWrEn <= 1'b1;
          MemAddr <= AW'(OUT_BASE) + idx;
        end
        WR: begin
          MemWrEn <= 1'b0;
          lfsr    <= {lfsr[LW-2:0], ^(lfsr & taps)};
          idx     <= idx + AW'(1);
          if (idx == LAST_IDX) begin
            state <= DONE;
            Ack   <= 1'b1;
          end else begin
            state   <= RD;
            MemAddr <= msg_addr(idx + AW'(1), pre);
          end
        end
        DONE: begin
          if (Start) begin
            state <= IDLE;
            Ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_pad_encrypt.sv
// Bench for lfsr_pad_encrypt: synchronous data-memory model, reference keystream model feeding
// a write scoreboard, a table of known-answer runs, and hand-written handshake/reset sequences.
module tb_lfsr_pad_encrypt;

  typedef struct {
    int         sel;
    logic [3:0] pre;
    logic [7:0] taps;
    logic [7:0] init;
    int         addr;
    logic [7:0] val;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_data;
  logic [7:0] mem [256];
  logic [7:0] msg_img [61];
  wr_t        sb [$];
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  lfsr_pad_encrypt dut (
    .Clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  // Synchronous-read data memory; the bench preload port has priority while the DUT is idle.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (MemWrEn) mem[MemAddr] <= MemWrData;
    MemRdData <= mem[MemAddr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_mem(input int a, input logic [7:0] d);
    tb_we   = 1'b1;
    tb_addr = 8'(a);
    tb_data = d;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  function automatic void push_expected(input logic [3:0] pre, input logic [6:0] taps,
                                        input logic [6:0] init);
    logic [6:0] r;
    logic [6:0] x;
    logic [6:0] c;
    wr_t        w;
    int         j;
    r = init;
    for (int i = 0; i < 64; i++) begin
      j = i - int'(pre);
      if (j < 0 || j >= 61) x = 7'h00;
      else x = 7'(msg_img[j] - 8'h20);
      c = x ^ r;
      w.addr = 8'(64 + i);
      w.data = {^c, c};
      sb.push_back(w);
      r = {r[5:0], ^(r & taps)};
    end
  endfunction

  // sel 0: Watson message, 1: "A" then spaces, other: random bytes.
  task automatic setup(input int sel, input logic [3:0] pre, input logic [7:0] taps,
                       input logic [7:0] init);
    string s;
    s = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 61; k++) begin
      if (sel == 0) msg_img[k] = (k < s.len()) ? s[k] : 8'h20;
      else if (sel == 1) msg_img[k] = (k == 0) ? 8'h41 : 8'h20;
      else msg_img[k] = 8'($urandom_range(0, 255));
    end
    for (int k = 0; k < 61; k++) wr_mem(k, msg_img[k]);
    wr_mem(61, {4'h0, pre});
    wr_mem(62, taps);
    wr_mem(63, init);
    for (int k = 64; k < 128; k++) wr_mem(k, 8'hEE);
    sb.delete();
    push_expected(pre, taps[6:0], init[6:0]);
  endtask

  task automatic sb_check();
    wr_t w;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected_write: addr 0x%0h data 0x%0h with no write expected",
               MemAddr, MemWrData);
    end else begin
      w = sb.pop_front();
      check("wr_addr", int'(MemAddr), int'(w.addr));
      check("wr_data", int'(MemWrData), int'(w.data));
      check("wr_parity", int'(^MemWrData), 0);
    end
  endtask

  // Launch a run with Start high for hold_hi samples; ack_edge counts edges after E0.
  task automatic do_run(input int hold_hi, input bit toggle, output int ack_edge, output int n_wr);
    @(negedge clk);
    Start = 1'b1;
    repeat (hold_hi) @(negedge clk);
    Start = 1'b0;
    ack_edge = -1;
    n_wr = 0;
    for (int m = 0; m < 200; m++) begin
      @(negedge clk);
      if (toggle && (m == 20 || m == 60)) Start = 1'b1;
      if (toggle && (m == 21 || m == 61)) Start = 1'b0;
      if (MemWrEn) begin
        n_wr++;
        sb_check();
      end
      if (Ack) begin
        ack_edge = m;
        break;
      end
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    check("ack_drop", int'(Ack), 0);
  endtask

  task automatic finish_checks(input int ack_e, input int nw);
    check("ack_edge", ack_e, 132);
    check("n_writes", nw, 64);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    vec_t       vecs [8];
    logic [7:0] taps_tab [9];
    logic [7:0] tb_taps;
    logic [7:0] tb_init;
    int         ack_e;
    int         nw;
    int         busy;
    int         bad;

    vecs[0] = '{0, 4'd10, 8'h60, 8'h01, 64, 8'h81};
    vecs[1] = '{0, 4'd10, 8'h60, 8'h01, 65, 8'h82};
    vecs[2] = '{0, 4'd10, 8'h60, 8'h01, 69, 8'hA0};
    vecs[3] = '{0, 4'd10, 8'h60, 8'h01, 70, 8'h41};
    vecs[4] = '{0, 4'd10, 8'h60, 8'h01, 74, 8'h35};
    vecs[5] = '{1, 4'd15, 8'h60, 8'h00, 79, 8'h21};
    vecs[6] = '{1, 4'd15, 8'h60, 8'h00, 78, 8'h00};
    vecs[7] = '{1, 4'd15, 8'h60, 8'h00, 127, 8'h00};
    taps_tab = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};

    Reset   = 1'b0;
    Start   = 1'b0;
    tb_we   = 1'b0;
    tb_addr = 8'h00;
    tb_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ack", int'(Ack), 0);
    check("reset_wren", int'(MemWrEn), 0);
    check("reset_addr", int'(MemAddr), 0);
    check("reset_wdata", int'(MemWrData), 0);
    Reset = 1'b1;

    // Start held low out of reset must not launch a run
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (MemWrEn || Ack || MemAddr != 8'h00) busy++;
    end
    check("no_launch_low", busy, 0);

    foreach (vecs[v]) begin
      setup(vecs[v].sel, vecs[v].pre, vecs[v].taps, vecs[v].init);
      do_run(1, 1'b0, ack_e, nw);
      finish_checks(ack_e, nw);
      check($sformatf("vec%0d_mem%0d", v, vecs[v].addr), int'(mem[vecs[v].addr]),
            int'(vecs[v].val));
      release_start();
    end

    // Reset sampled at E40: bytes 0..17 land, nothing after
    setup(0, 4'd10, 8'h60, 8'h01);
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    nw = 0;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (MemWrEn) begin
        nw++;
        sb_check();
      end
    end
    Reset = 1'b0;
    sb.delete();
    check("rst_writes_before", nw, 18);
    @(negedge clk);
    check("rst_ack", int'(Ack), 0);
    check("rst_wren", int'(MemWrEn), 0);
    check("rst_addr", int'(MemAddr), 0);
    @(negedge clk);
    Reset = 1'b1;
    busy = 0;
    repeat (150) begin
      @(negedge clk);
      if (MemWrEn || Ack) busy++;
    end
    check("rst_quiet", busy, 0);
    bad = 0;
    for (int k = 82; k < 128; k++) if (mem[k] !== 8'hEE) bad++;
    check("rst_mem_kept", bad, 0);
    setup(0, 4'd10, 8'h60, 8'h01);
    do_run(1, 1'b0, ack_e, nw);
    finish_checks(ack_e, nw);
    release_start();

    // Long Start-high, mid-run toggles, Ack held until Start returns high
    setup(0, 4'd12, 8'h48, 8'h35);
    do_run(50, 1'b1, ack_e, nw);
    finish_checks(ack_e, nw);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (!Ack || MemWrEn) busy++;
    end
    check("ack_hold", busy, 0);
    release_start();
    busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (MemWrEn || Ack) busy++;
    end
    check("no_rerun", busy, 0);

    // Sweep: every tap pattern, every pad length, random init and message, bit 7 noise
    for (int t = 0; t < 9; t++) begin
      for (int p = 10; p <= 15; p++) begin
        tb_taps = taps_tab[t] | {1'($urandom_range(0, 1)), 7'h00};
        tb_init = 8'($urandom_range(1, 255));
        setup(2, 4'(p), tb_taps, tb_init);
        do_run(1, 1'b0, ack_e, nw);
        finish_checks(ack_e, nw);
        release_start();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_pad_encrypt.md
# lfsr_pad_encrypt

Hardware encryptor that produces the 64-byte ciphertext the message-decryption programs consume. It reads a plaintext ASCII message and three configuration bytes from data memory. It left-pads the message with `pre_length` space characters and removes the 0x20 ASCII offset. It XORs each byte with a 7-bit maximal-length LFSR stream, places even parity in bit 7, and writes the 64 results back to data memory. It sits beside the program core as a memory master and uses the same Start/Ack program handshake as TopLevel.

## Interface
- `MSG_BASE`, default 0: address of plaintext byte 0. Plaintext is stored as ASCII, space-filled through `MSG_BASE+60`.
- `CFG_BASE`, default 61: address of `pre_length`. `CFG_BASE+1` holds the tap pattern; `CFG_BASE+2` holds the LFSR init value.
- `OUT_BASE`, default 64: address of ciphertext byte 0.
- `OUT_LEN`, default 64: number of ciphertext bytes written.
- `MSG_SPAN`, default 61: plaintext bytes available. A source index at or above this value is treated as a pad byte.
- `Clk` in 1: the block's only clock. All state updates on its rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `Start` in 1: program request. A run launches on the falling edge of `Start`.
- `Ack` out 1: run complete. Held high until `Start` is reasserted.
- `MemAddr` out 8: data-memory address.
- `MemWrEn` out 1: write strobe, asserted for one cycle per output byte.
- `MemWrData` out 8: write data.
- `MemRdData` in 8: read data. Valid one cycle after `MemAddr` is presented (synchronous read).

## Operation
- Reset (`Reset`=0 at an edge) drives state to IDLE. It clears `Ack`, `MemWrEn`, `MemAddr`, `MemWrData`, the byte index and the internal config registers to 0.
- States, in order: IDLE, C0, C1, C2, C3, RD, WR, DONE.
- IDLE: the block registers `Start` each cycle. It moves to C0 on an edge where `Start`=0 and the previous sample was 1. A `Start` held low out of reset never launches a run.
- C0: drive `MemAddr`=`CFG_BASE`.
- C1: drive `CFG_BASE+1`.
- C2: drive `CFG_BASE+2`; capture `pre`=`MemRdData[3:0]`.
- C3: capture `taps`=`MemRdData[6:0]`.
- C3 to RD: capture `lfsr`=`MemRdData[6:0]` and set i=0.
- Byte i loop, 0..`OUT_LEN`-1, with j = i - `pre`:
  - RD: drive `MemAddr`=`MSG_BASE+j[5:0]`, but only when i ≥ `pre` and j < `MSG_SPAN`.
  - WR: the byte is a pad if i < `pre` or j ≥ `MSG_SPAN`. Otherwise x = (`MemRdData` - 0x20) mod 128. A pad byte has x = 0.
  - WR: c[6:0] = x ^ `lfsr`; c[7] = ^c[6:0]. Drive `MemWrData`=c, `MemAddr`=`OUT_BASE+i`, `MemWrEn`=1.
  - WR: at the edge leaving WR, `lfsr` ← {`lfsr`[5:0], ^(`lfsr` & `taps`)} and i ← i+1.
- Pad bytes still take the full RD+WR pair, so latency is data-independent. `MemAddr` in a pad RD cycle is don't-care and no write occurs in it.
- After WR of i=`OUT_LEN`-1, go to DONE with `Ack`=1.
- DONE to IDLE when `Start`=1; `Ack` drops at that edge.
- `Start` changes during C0..WR are ignored.
- An LFSR init of 0 is used as-is (all-zero keystream, intended for debug). It is not remapped.
- Only 7 bits are used for `taps` and `lfsr`; bit 7 of those config bytes is ignored.
- `MemWrEn`=0 in every state except WR. No write ever targets an address below `OUT_BASE`.

## Timing
- Let E0 be the edge that samples `Start`=0 following a `Start`=1 sample.
- C0..C3 occupy E0..E3. The first RD begins at E4.
- Byte i is written in the cycle after edge E5+2i.
- `Ack` rises at edge E4+2·`OUT_LEN`, which is E132 for the defaults.
- Reset mid-run: at the next edge, state goes to IDLE and outputs go to reset values. Bytes already written remain and no further write occurs.
- Reset and a `Start` edge in the same cycle: reset wins.

## Test plan
- Leading pad bytes. Config `pre`=10, `taps`=0x60, init=0x01; message "Mr. Watson, come here. I want to see you." (rest 0x20).
  - Mem[64] must be 0x81, Mem[65] 0x82, Mem[69] 0xA0, Mem[70] 0x41.
- First message byte, same run as above: Mem[74] ('M', lfsr 0x18) must be 0x35. `Ack` rises exactly 132 edges after E0.
- Zero keystream. init=0, `pre`=15, message "A" followed by spaces.
  - Mem[64..78] must all be 0x00, Mem[79] 0x21, Mem[80..127] 0x00.
  - No write occurs to any address below 64.
- Reset mid-run. Assert `Reset`=0 at E40 of a run.
  - `Ack` stays 0, `MemWrEn` stays 0 from E41 onward, Mem[82..127] is unchanged.
  - A fresh `Start` pulse then completes normally.
- Handshake. Hold `Start`=1 for 50 cycles, then low.
  - Exactly one run occurs and `Ack` stays high until `Start` returns to 1.
  - Toggling `Start` mid-run neither restarts nor aborts the run.
- Full sweep. For all 9 tap patterns (0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B) × random init × `pre` in 10..15:
  - All 64 bytes must match a reference model.
  - Every output byte must have even parity.
